matriz_determ_seq: RTL and testbench
====================================

Name: matriz_determ_seq

Overview:
- Sequential, parametrised determinant unit for signed KxK matrices, with K selectable at run time from 1 to MAX_N.
- The operand is the top-left KxK sub-block of a packed MAX_N x MAX_N matrix.
- Uses a single multiplier and sums over all K! permutations (Leibniz expansion), with a full-width accumulator and a start/busy/done handshake.
- Sits in the coprocessor ULA beside the other matrix operators and replaces the fixed 3x3, 8-bit-truncated combinational determinant.

Parameters:
- DATA_W, 8: element width, two's complement.
- MAX_N, 5: largest matrix dimension; packed input is MAX_N x MAX_N.
- ACC_W, 48: product and accumulator width. Default is exact for 5x5 of 8-bit values.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- size  in  3  K; valid range 1..MAX_N; captured with start.
- matriz_A  in  MAX_N*MAX_N*DATA_W  row-major; element (i,j) = bits [(i*MAX_N+j)*DATA_W +: DATA_W]; captured with start.
- busy  out  1  high from the capture edge until done.
- done  out  1  one-cycle pulse when det is valid.
- det  out  ACC_W  signed determinant; holds until the next done.
- err  out  1  high with done when size was invalid; holds until the next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, err = 0; det=0; internal registers cleared.
- Reset mid-operation aborts the computation; no done is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 captures matriz_A and size, clears acc, clears the Lehmer counter and term index j, sets busy.
  - Valid size -> RUN. size=0 or size>MAX_N -> FINISH with the err flag set.
- start while busy is ignored; captured operands are unaffected.
- Permutation generation:
  - A mixed-radix Lehmer counter has digits d[t] in 0..K-1-t.
  - Permutation p is derived combinationally from the counter.
  - sign = parity of the sum of the digits (odd = negative).
- RUN, one multiply per cycle:
  - j=0: prod <= sext(a[0][p0]).
  - j>0: prod <= prod*sext(a[j][pj]), truncated to ACC_W.
  - j=K-1: acc <= acc +/- final product, using the sign.
  - If the counter is at its last value -> FINISH. Otherwise increment the counter and set j <= 0.
- FINISH: det <= acc (0 on err); err updated; done=1 for one cycle; busy=0 -> IDLE.
- A new start is accepted in the cycle after done.
- Latency: done is high after edge K*K!+1, counting the start-capture edge as 0.
  - K=1: 2, K=2: 5, K=3: 19, K=4: 97, K=5: 601.
  - Invalid size: 1.
- Arithmetic:
  - All math is signed two's complement.
  - Wrap-around at ACC_W is silent.
  - For ACC_W >= MAX_N*DATA_W + 7 the result is exact for MAX_N<=5.

Optional Feature:
- Macro: DET_SAT_OUT_EN.
- When defined, adds output port det_sat (DATA_W).
  - Holds det saturated to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Registered with det; reset 0.
- When undefined, the port and the saturation logic are absent. All other behaviour is identical.

Test Plan:
- K=3, rows [2,-1,0],[1,3,2],[0,1,4], unused elements random -> done at edge 19, det=24, err=0; busy high for edges 0..18.
- K=2, [127,-128],[-128,127] -> det=-255 at edge 5; with DET_SAT_OUT_EN, det_sat=-128.
- K=5, diag(10,-2,3,4,5), off-diagonal 0 -> done at edge 601, det=-1200. Also K=1, a00=-7 -> det=-7 at edge 2.
- Invalid size:
  - size=0 -> done at edge 1, err=1, det=0.
  - size=6 -> same response.
  - Then a valid K=2 identity -> det=1, err=0.
- Start while busy: pulse start with a different matrix at edge 5 of a K=3 run -> ignored; det=24 at edge 19. A start in the cycle after done is accepted.
- Reset mid-run: assert rst_n low at edge 50 of a K=5 run.
  - busy, done, det go 0 immediately and no done appears.
  - A subsequent K=3 run returns the correct det.

Source files
------------

// File: rtl/matriz_determ_seq.sv
// matriz_determ_seq: sequential signed determinant of the top-left KxK block of a
// packed MAX_N x MAX_N matrix, K = 1..MAX_N chosen per operation. One multiplier walks
// every permutation (Leibniz expansion) from a mixed-radix Lehmer counter; one multiply
// per cycle, so done rises K*K!+1 edges after the start-capture edge.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request, sampled only while idle
//   size         K, captured with start; 0 or > MAX_N flags err
//   matriz_A     row-major, element (i,j) at [(i*MAX_N+j)*DATA_W +: DATA_W]
//   busy         high from the capture edge until done
//   done         one-cycle result strobe
//   det          signed determinant, holds until the next done
//   err          invalid size, valid with done, holds until the next done
//   det_sat      (only with `DET_SAT_OUT_EN) det clamped to the signed DATA_W range
//
// Build option: define DET_SAT_OUT_EN to add the det_sat output.
module matriz_determ_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5,
  parameter int unsigned ACC_W  = 48
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [2:0]                      size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matriz_A,
  output logic                            busy,
  output logic                            done,
  output logic signed [ACC_W-1:0]         det,
  output logic                            err
`ifdef DET_SAT_OUT_EN
  ,
  output logic signed [DATA_W-1:0]        det_sat
`endif
);

  localparam int unsigned IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int unsigned MW = MAX_N * MAX_N * DATA_W;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e                       state_q, state_d;
  logic [MW-1:0]                mat_q, mat_d;
  logic [2:0]                   size_q, size_d;
  logic [MAX_N-1:0][IW-1:0]     dig_q, dig_d;
  logic [IW-1:0]                j_q, j_d;
  logic signed [ACC_W-1:0]      prod_q, prod_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic                         inv_q, inv_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic signed [ACC_W-1:0]      det_q, det_d;
  logic                         err_q, err_d;

  // Datapath helpers
  int                           kk;
  int                           cnt;
  logic                         found;
  logic [MAX_N-1:0]             used;
  logic [MAX_N-1:0][IW-1:0]     perm;
  logic [IW-1:0]                pj;
  logic [DATA_W-1:0]            elem;
  logic signed [ACC_W-1:0]      elem_ext;
  logic signed [ACC_W-1:0]      prod_nxt;
  logic                         neg;
  logic                         last;
  logic                         carry;
  logic [MAX_N-1:0][IW-1:0]     dig_inc;
  logic                         size_ok;

  // Lehmer code -> permutation: p[t] is the dig[t]-th smallest column not yet used.
  always_comb begin
    kk    = int'(size_q);
    used  = '0;
    perm  = '0;
    cnt   = 0;
    found = 1'b0;
    for (int t = 0; t < int'(MAX_N); t++) begin
      cnt   = 0;
      found = 1'b0;
      for (int c = 0; c < int'(MAX_N); c++) begin
        if (!found && !used[c] && (c < kk)) begin
          if (cnt == int'(dig_q[t])) begin
            perm[t] = IW'(c);
            used[c] = 1'b1;
            found   = 1'b1;
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  // Operand a[j][p_j], product chain, sign, end-of-sweep and counter increment.
  always_comb begin
    pj = '0;
    for (int t = 0; t < int'(MAX_N); t++) begin
      if (t == int'(j_q)) pj = perm[t];
    end
    elem = '0;
    for (int i = 0; i < int'(MAX_N); i++) begin
      for (int c = 0; c < int'(MAX_N); c++) begin
        if ((i == int'(j_q)) && (c == int'(pj))) begin
          elem = mat_q[(i*MAX_N+c)*DATA_W +: DATA_W];
        end
      end
    end
    elem_ext = {{(ACC_W-DATA_W){elem[DATA_W-1]}}, elem};
    prod_nxt = (j_q == '0) ? elem_ext : prod_q * elem_ext;

    // Sum of digits equals the inversion count, so its parity is the permutation sign.
    neg  = 1'b0;
    last = 1'b1;
    for (int t = 0; t < int'(MAX_N); t++) begin
      neg = neg ^ dig_q[t][0];
      if ((t < kk) && (int'(dig_q[t]) != kk - 1 - t)) last = 1'b0;
    end

    // Digit K-1 is least significant; digit t wraps after K-1-t.
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int t = int'(MAX_N) - 1; t >= 0; t--) begin
      if (carry && (t < kk)) begin
        if (int'(dig_q[t]) == kk - 1 - t) begin
          dig_inc[t] = '0;
        end else begin
          dig_inc[t] = dig_q[t] + 1'b1;
          carry      = 1'b0;
        end
      end
    end
  end

  assign size_ok = (size != 3'd0) && (int'(size) <= int'(MAX_N));

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    size_d  = size_q;
    dig_d   = dig_q;
    j_d     = j_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    inv_d   = inv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    det_d   = det_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mat_d   = matriz_A;
          size_d  = size;
          dig_d   = '0;
          j_d     = '0;
          prod_d  = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          inv_d   = !size_ok;
          state_d = size_ok ? StRun : StFinish;
        end
      end
      StRun: begin
        prod_d = prod_nxt;
        if (int'(j_q) == kk - 1) begin
          acc_d = neg ? acc_q - prod_nxt : acc_q + prod_nxt;
          j_d   = '0;
          if (last) begin
            state_d = StFinish;
          end else begin
            dig_d = dig_inc;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StFinish: begin
        det_d   = inv_q ? '0 : acc_q;
        err_d   = inv_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mat_q   <= '0;
      size_q  <= '0;
      dig_q   <= '0;
      j_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      det_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      size_q  <= size_d;
      dig_q   <= dig_d;
      j_q     <= j_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      det_q   <= det_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign det  = det_q;
  assign err  = err_q;

`ifdef DET_SAT_OUT_EN
  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  logic signed [DATA_W-1:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (state_q == StFinish) begin
      if (inv_q)                sat_d = '0;
      else if (acc_q > SatMax)  sat_d = {1'b0, {(DATA_W-1){1'b1}}};
      else if (acc_q < SatMin)  sat_d = {1'b1, {(DATA_W-1){1'b0}}};
      else                      sat_d = acc_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end

  assign det_sat = sat_q;
`endif

endmodule

// File: tb/tb_matriz_determ_seq.sv
// Bench for matriz_determ_seq: each accepted start pushes its expected det/err/latency
// onto a scoreboard; a negedge monitor pops and compares on every done.
module tb_matriz_determ_seq;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 5;
  localparam int ACC_W  = 48;
  localparam int MW     = MAX_N * MAX_N * DATA_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [2:0]               size = '0;
  logic [MW-1:0]            matriz_A = '0;
  logic                     busy;
  logic                     done;
  logic signed [ACC_W-1:0]  det;
  logic                     err;
`ifdef DET_SAT_OUT_EN
  logic signed [DATA_W-1:0] det_sat;
`endif

  matriz_determ_seq #(
    .DATA_W (DATA_W),
    .MAX_N  (MAX_N),
    .ACC_W  (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .size     (size),
    .matriz_A (matriz_A),
    .busy     (busy),
    .done     (done),
    .det      (det),
    .err      (err)
`ifdef DET_SAT_OUT_EN
    ,
    .det_sat  (det_sat)
`endif
  );

  typedef struct {
    longint det;
    logic   err;
    int     lat;
    int     cap;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_num = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_num <= edge_num + 1;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat_model(input longint v);
    if (v > 127)       return 127;
    else if (v < -128) return -128;
    else               return v;
  endfunction

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int i, input int j,
                                        input int v);
    logic [MW-1:0] r;
    r = m;
    r[(i*MAX_N+j)*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] r;
    r = '0;
    for (int e = 0; e < MAX_N * MAX_N; e++) r[e*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  // Called just after a negedge; returns 1 time unit after the capture edge.
  task automatic run(input logic [MW-1:0] m, input logic [2:0] sz, input longint exp_det,
                     input logic exp_err, input int lat);
    exp_t it;
    matriz_A = m;
    size     = sz;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    it.det  = exp_det;
    it.err  = exp_err;
    it.lat  = lat;
    it.cap  = edge_num;
    sb.push_back(it);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check_val("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check_val("spurious_done", done, 0);
        end else begin
          exp_t it;
          it = sb.pop_front();
          check_val("det", det, it.det);
          check_val("err", err, it.err);
          check_val("latency", edge_num - it.cap, it.lat);
          check_val("busy_at_done", busy, 0);
`ifdef DET_SAT_OUT_EN
          check_val("det_sat", det_sat, sat_model(it.det));
`endif
        end
      end else if (sb.size() != 0) begin
        check_val("busy_while_running", busy, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] m3, m;

    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_det", det, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // K=3 reference with random unused elements
    m3 = rand_mat();
    m3 = put(m3, 0, 0, 2);  m3 = put(m3, 0, 1, -1); m3 = put(m3, 0, 2, 0);
    m3 = put(m3, 1, 0, 1);  m3 = put(m3, 1, 1, 3);  m3 = put(m3, 1, 2, 2);
    m3 = put(m3, 2, 0, 0);  m3 = put(m3, 2, 1, 1);  m3 = put(m3, 2, 2, 4);
    run(m3, 3'd3, 24, 1'b0, 19);
    wait_idle(100);

    // K=2 extremes; det exceeds DATA_W range
    m = rand_mat();
    m = put(m, 0, 0, 127);  m = put(m, 0, 1, -128);
    m = put(m, 1, 0, -128); m = put(m, 1, 1, 127);
    run(m, 3'd2, -255, 1'b0, 5);
    wait_idle(100);

    // K=1
    m = rand_mat();
    m = put(m, 0, 0, -7);
    run(m, 3'd1, -7, 1'b0, 2);
    wait_idle(100);

    // K=5 diagonal
    m = '0;
    m = put(m, 0, 0, 10); m = put(m, 1, 1, -2); m = put(m, 2, 2, 3);
    m = put(m, 3, 3, 4);  m = put(m, 4, 4, 5);
    run(m, 3'd5, -1200, 1'b0, 601);
    wait_idle(1000);

    // Invalid sizes
    run(rand_mat(), 3'd0, 0, 1'b1, 1);
    wait_idle(100);
    run(rand_mat(), 3'd6, 0, 1'b1, 1);
    wait_idle(100);

    // K=2 identity clears err
    m = rand_mat();
    m = put(m, 0, 0, 1); m = put(m, 0, 1, 0);
    m = put(m, 1, 0, 0); m = put(m, 1, 1, 1);
    run(m, 3'd2, 1, 1'b0, 5);
    wait_idle(100);

    // K=4 upper triangular, random above diagonal
    m = rand_mat();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < i; j++) m = put(m, i, j, 0);
    m = put(m, 0, 0, 1); m = put(m, 1, 1, 2); m = put(m, 2, 2, 3); m = put(m, 3, 3, -4);
    run(m, 3'd4, -24, 1'b0, 97);
    wait_idle(300);

    // Start pulsed at edge 5 of a K=3 run must be ignored
    run(m3, 3'd3, 24, 1'b0, 19);
    repeat (5) @(negedge clk);
    matriz_A = rand_mat();
    size     = 3'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(100);

    // Reset at edge 50 of a K=5 run aborts it
    m = '0;
    m = put(m, 0, 0, 10); m = put(m, 1, 1, -2); m = put(m, 2, 2, 3);
    m = put(m, 3, 3, 4);  m = put(m, 4, 4, 5);
    run(m, 3'd5, -1200, 1'b0, 601);
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_det", det, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_val("idle_after_abort", busy, 0);
    #1;

    run(m3, 3'd3, 24, 1'b0, 19);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
